exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter DIV_ITER, default 32, sets the number of divider iteration cycles and SHALL only be legal at 32.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ex_ctrl_bus  input  191  Fields {md_op[2:0] 190:188, is_break 187, op_mem[5:0] 186:181, alu_op[13:0] 180:167, inst_valid 166, Imm 165:134, PC 133:102, Inst 101:70, wreg_index 69:65, wreg_en 64, src2 63:32, src1 31:0}.
REQ-005 mem_ctrl_bus  output  220  Fields {is_break 219, op_mem 218:213, alu_op 212:199, inst_valid 198, Imm 197:166, PC 165:134, Inst 133:102, wreg_index 101:97, wreg_en 96, src2 95:64, src1 63:32, ex_result 31:0}.
REQ-006 ex_bypass  output  39  Fields {ex_result[31:0], wreg_index[4:0], wreg_en & out_valid, is_load = op_mem[0] & ~op_mem[2]}, all taken from the output register.
REQ-007 left_valid  input  1  upstream data valid.
REQ-008 left_ready  output  1  stage accepts input.
REQ-009 right_valid  output  1  mem_ctrl_bus valid.
REQ-010 right_ready  input  1  downstream accepts.

Function
REQ-011 alu_op is one-hot, bit0..13 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (pass src2), andn (src1 & ~src2), orn; shift amount = src2[4:0].
REQ-012 md_op encodings: 000 none (ALU result), 001 mul low 32, 010 mulh signed, 011 mulh unsigned, 100 div signed, 101 mod signed, 110 div unsigned, 111 mod unsigned.
REQ-013 Multiply results SHALL be computed in the accept cycle from the 64-bit product, with no extra latency.
REQ-014 out_valid register: left_ready = (state==IDLE) & (~out_valid | right_ready); accept = left_valid & left_ready.
REQ-015 Non-divide accept SHALL load the output register at that edge, giving right_valid the next cycle (1-cycle latency).
REQ-016 out_valid SHALL clear on right_valid & right_ready unless a load occurs at the same edge; simultaneous drain and load SHALL keep it 1 (full throughput).
REQ-017 Divide FSM states: IDLE, BUSY, DONE. A divide accept SHALL latch the bus and move IDLE->BUSY. BUSY runs DIV_ITER restoring-division cycles, then moves to DONE. In DONE, when (~out_valid | right_ready), the FSM SHALL load the output register and return to IDLE.
REQ-018 Divide latency SHALL be accept-to-right_valid = 34 cycles when downstream is free; left_ready SHALL be 0 throughout BUSY and DONE.
REQ-019 Signed divide SHALL operate on magnitudes: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-020 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend.
REQ-021 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0.
REQ-022 Output register contents SHALL remain stable while right_valid & ~right_ready.
REQ-023 inst_valid=0 entries SHALL flow through normally and SHALL never start the divider.

Reset
REQ-024 Reset SHALL set out_valid=0, state=IDLE, divider registers=0, and mem_ctrl_bus=0, so that right_valid=0, ex_bypass=0, and left_ready=1 immediately after reset.
REQ-025 Reset during BUSY/DONE SHALL abort the divide; no result SHALL be emitted afterwards.

Structure
REQ-026 defines.sv SHALL hold `id_ctrl_width 191, `ex_ctrl_width 220, `ex_bypass_width 39, the md_op encodings, and the FSM state encodings.
REQ-027 The iterative divider SHALL be a sub-module, div_unit (start, signed, dividend, divisor -> busy, done, quotient, remainder).

Verification
REQ-028 add src1=5, src2=0xFFFFFFFF with right_ready=1 -> next cycle right_valid=1, ex_result=4.
REQ-029 div signed 0xFFFFFFF9 / 2 -> right_valid 34 cycles after accept, ex_result=0xFFFFFFFD; mod gives 0xFFFFFFFF; left_ready=0 for 33 cycles.
REQ-030 divu 7 / 0 -> ex_result=0xFFFFFFFF; modu 7 / 0 -> ex_result=7.
REQ-031 Back-to-back ALU ops, right_ready=0 for 3 cycles, then 1 -> bus held constant, left_ready=0 while stalled, no op lost or duplicated.
REQ-032 Reset asserted at BUSY cycle 10 -> right_valid=0 immediately, left_ready=1; no stray result after release.
REQ-033 mulh signed 0x80000000 * 0x80000000 -> ex_result=0x40000000; mul low gives 0.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared widths, multiply/divide opcodes and divide-sequencer states for the execute stage.
package exe_stage_pkg;
  localparam int ID_CTRL_WIDTH   = 191;
  localparam int EX_CTRL_WIDTH   = 220;
  localparam int EX_BYPASS_WIDTH = 39;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MUL   = 3'b001;
  localparam logic [2:0] MD_MULH  = 3'b010;
  localparam logic [2:0] MD_MULHU = 3'b011;
  localparam logic [2:0] MD_DIV   = 3'b100;
  localparam logic [2:0] MD_MOD   = 3'b101;
  localparam logic [2:0] MD_DIVU  = 3'b110;
  localparam logic [2:0] MD_MODU  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    neg_if = neg ? (32'd0 - v) : v;
  endfunction
endpackage

// File: rtl/exe_stage_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs and the divide-by-zero result applied at the outputs.
module div_unit
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam logic [5:0] ITER_CNT = 6'(DIV_ITER);

  logic        busy_q, busy_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
  logic [32:0] shifted;

  // Operand load on start, then one restoring step per cycle.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    shifted   = {rem_q, quo_q[31]};
    if (start) begin
      busy_d    = 1'b1;
      cnt_d     = ITER_CNT;
      rem_d     = 32'd0;
      quo_d     = neg_if(sign_op & dividend[31], dividend);
      dsr_d     = neg_if(sign_op & divisor[31], divisor);
      neg_quo_d = sign_op & (dividend[31] ^ divisor[31]);
      neg_rem_d = sign_op & dividend[31];
      div0_d    = (divisor == 32'd0);
    end else if (busy_q) begin
      cnt_d  = cnt_q - 6'd1;
      busy_d = (cnt_q != 6'd1);
      if (shifted >= {1'b0, dsr_q}) begin
        rem_d = 32'(shifted - {1'b0, dsr_q});
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dsr_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  // done marks the cycle of the final step; results hold from the next cycle until a new start.
  assign busy      = busy_q;
  assign done      = busy_q & (cnt_q == 6'd1);
  assign quotient  = div0_q ? 32'hFFFF_FFFF : neg_if(neg_quo_q, quo_q);
  assign remainder = neg_if(neg_rem_q, rem_q);
endmodule

// File: rtl/exe_stage.sv
// Execute stage: one-hot ALU, single-cycle multiply and an iterative divider,
// all feeding a one-entry valid/ready output register.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ID_CTRL_WIDTH-1:0]   ex_ctrl_bus,
  output logic [EX_CTRL_WIDTH-1:0]   mem_ctrl_bus,
  output logic [EX_BYPASS_WIDTH-1:0] ex_bypass,
  input  logic                       left_valid,
  output logic                       left_ready,
  output logic                       right_valid,
  input  logic                       right_ready
);
  localparam int PASS_W = ID_CTRL_WIDTH - 3;

  logic [2:0]  md_op;
  logic [13:0] alu_op;
  logic        inst_valid;
  logic [31:0] src1, src2;
  logic [4:0]  shamt;

  div_state_e               state_q, state_d;
  logic                     out_valid_q, out_valid_d;
  logic [EX_CTRL_WIDTH-1:0] out_bus_q, out_bus_d;
  logic [PASS_W-1:0]        hold_q, hold_d;
  logic [2:0]               md_q, md_d;

  logic        accept, div_start, load_alu, load_div;
  logic [31:0] alu_res, ex_res, div_res;
  logic [63:0] prod_ss, prod_uu;
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;

  assign md_op      = ex_ctrl_bus[190:188];
  assign alu_op     = ex_ctrl_bus[180:167];
  assign inst_valid = ex_ctrl_bus[166];
  assign src2       = ex_ctrl_bus[63:32];
  assign src1       = ex_ctrl_bus[31:0];
  assign shamt      = src2[4:0];

  assign prod_ss = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
  assign prod_uu = {32'd0, src1} * {32'd0, src2};

  // One-hot ALU select.
  always_comb begin
    alu_res = 32'd0;
    case (1'b1)
      alu_op[0]:  alu_res = src1 + src2;
      alu_op[1]:  alu_res = src1 - src2;
      alu_op[2]:  alu_res = {31'd0, $signed(src1) < $signed(src2)};
      alu_op[3]:  alu_res = {31'd0, src1 < src2};
      alu_op[4]:  alu_res = src1 & src2;
      alu_op[5]:  alu_res = ~(src1 | src2);
      alu_op[6]:  alu_res = src1 | src2;
      alu_op[7]:  alu_res = src1 ^ src2;
      alu_op[8]:  alu_res = src1 << shamt;
      alu_op[9]:  alu_res = src1 >> shamt;
      alu_op[10]: alu_res = 32'($signed(src1) >>> shamt);
      alu_op[11]: alu_res = src2;
      alu_op[12]: alu_res = src1 & ~src2;
      alu_op[13]: alu_res = src1 | ~src2;
      default:    alu_res = 32'd0;
    endcase
  end

  // Accept-cycle result: ALU or multiply; divide opcodes with inst_valid=0 fall back to the ALU.
  always_comb begin
    ex_res = alu_res;
    case (md_op)
      MD_NONE:  ex_res = alu_res;
      MD_MUL:   ex_res = prod_ss[31:0];
      MD_MULH:  ex_res = prod_ss[63:32];
      MD_MULHU: ex_res = prod_uu[63:32];
      default:  ex_res = alu_res;
    endcase
  end

  // Divider result selection by the latched opcode.
  always_comb begin
    div_res = div_quo;
    case (md_q)
      MD_DIV, MD_DIVU: div_res = div_quo;
      MD_MOD, MD_MODU: div_res = div_rem;
      default:         div_res = div_quo;
    endcase
  end

  div_unit #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .sign_op   ((md_op == MD_DIV) | (md_op == MD_MOD)),
    .dividend  (src1),
    .divisor   (src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Handshake, divide sequencer and output register next-state.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_bus_d   = out_bus_q;
    hold_d      = hold_q;
    md_d        = md_q;
    left_ready  = (state_q == ST_IDLE) & (~out_valid_q | right_ready);
    accept      = left_valid & left_ready;
    div_start   = accept & inst_valid & md_op[2];
    load_alu    = accept & ~div_start;
    load_div    = (state_q == ST_DONE) & (~out_valid_q | right_ready);

    case (state_q)
      ST_IDLE: if (div_start) state_d = ST_BUSY; else state_d = ST_IDLE;
      // A BUSY state with an idle divider cannot finish, so fall back to IDLE.
      ST_BUSY: if (div_done) state_d = ST_DONE;
               else if (div_busy) state_d = ST_BUSY;
               else state_d = ST_IDLE;
      ST_DONE: if (load_div) state_d = ST_IDLE; else state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (div_start) begin
      hold_d = ex_ctrl_bus[PASS_W-1:0];
      md_d   = md_op;
    end else begin
      hold_d = hold_q;
      md_d   = md_q;
    end

    if (load_alu) out_bus_d = {ex_ctrl_bus[PASS_W-1:0], ex_res};
    else if (load_div) out_bus_d = {hold_q, div_res};
    else out_bus_d = out_bus_q;

    if (load_alu | load_div) out_valid_d = 1'b1;
    else if (right_ready) out_valid_d = 1'b0;
    else out_valid_d = out_valid_q;
  end

  // Stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_bus_q   <= '0;
      hold_q      <= '0;
      md_q        <= 3'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_bus_q   <= out_bus_d;
      hold_q      <= hold_d;
      md_q        <= md_d;
    end
  end

  assign mem_ctrl_bus = out_bus_q;
  assign right_valid  = out_valid_q;
  assign ex_bypass    = {out_bus_q[31:0], out_bus_q[101:97], out_bus_q[96] & out_valid_q,
                         out_bus_q[213] & ~out_bus_q[215]};
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed corner cases plus randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_exe_stage;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [190:0] ex_ctrl_bus = '0;
  logic [219:0] mem_ctrl_bus;
  logic [38:0]  ex_bypass;
  logic         left_valid = 1'b0;
  logic         left_ready;
  logic         right_valid;
  logic         right_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  logic [219:0] exp_q[$];

  exe_stage #(.DIV_ITER(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_ctrl_bus  (ex_ctrl_bus),
    .mem_ctrl_bus (mem_ctrl_bus),
    .ex_bypass    (ex_bypass),
    .left_valid   (left_valid),
    .left_ready   (left_ready),
    .right_valid  (right_valid),
    .right_ready  (right_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [219:0] got, input logic [219:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [190:0] mk_bus(input logic [2:0] md, input logic [13:0] alu,
                                          input logic iv, input logic [31:0] a, input logic [31:0] b);
    return {md, 1'($urandom), 6'($urandom), alu, iv, $urandom, $urandom, $urandom,
            5'($urandom), 1'($urandom), b, a};
  endfunction

  function automatic logic [31:0] ref_result(input logic [190:0] bus);
    logic [31:0] a, b, q, r, res;
    logic [2:0]  md;
    logic [13:0] op;
    longint      ps;
    logic [63:0] pu;
    int          idx;
    a = bus[31:0]; b = bus[63:32]; md = bus[190:188]; op = bus[180:167];
    if (bus[166] && md[2]) begin
      if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
      else if (!md[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 32'd0; end
      else if (!md[1]) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
      return md[0] ? r : q;
    end
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    if (md == 3'd1) return ps[31:0];
    if (md == 3'd2) return ps[63:32];
    if (md == 3'd3) return pu[63:32];
    idx = -1;
    for (int i = 0; i < 14; i++) if (op[i] && idx < 0) idx = i;
    case (idx)
      0: res = a + b;
      1: res = a - b;
      2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: res = (a < b) ? 32'd1 : 32'd0;
      4: res = a & b;
      5: res = ~(a | b);
      6: res = a | b;
      7: res = a ^ b;
      8: res = a << b[4:0];
      9: res = a >> b[4:0];
      10: res = 32'($signed(a) >>> b[4:0]);
      11: res = b;
      12: res = a & ~b;
      13: res = a | ~b;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic [219:0] exp_bus(input logic [190:0] bus);
    return {bus[187:0], ref_result(bus)};
  endfunction

  // Bypass view of a delivered entry: result, wreg_index, wreg_en, is_load from op_mem.
  function automatic logic [219:0] exp_bypass(input logic [219:0] e);
    logic [5:0] op_mem;
    op_mem = e[218:213];
    return 220'({e[31:0], e[101:97], e[96], op_mem[0] & ~op_mem[2]});
  endfunction

  function automatic logic [190:0] rand_bus();
    logic [2:0]  md;
    logic [31:0] a, b;
    int          sel;
    sel = $urandom_range(0, 19);
    md = (sel < 12) ? 3'd0 : (sel < 16) ? 3'($urandom_range(1, 3)) : 3'($urandom_range(4, 7));
    a = $urandom; b = $urandom;
    case ($urandom_range(0, 5))
      0: b = 32'd0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: b = b & 32'h0000_000F;
      default: ;
    endcase
    return mk_bus(md, 14'd1 << $urandom_range(0, 13), 1'($urandom_range(0, 7) != 0), a, b);
  endfunction

  always @(posedge reset) exp_q.delete();

  // Scoreboard: push at every accept, compare at every drain.
  always @(negedge clk) begin
    logic [219:0] e;
    if (!reset) begin
      if (right_valid && right_ready) begin
        if (exp_q.size() == 0) check("sb_extra", 220'(right_valid), 220'(1'b0));
        else begin
          e = exp_q.pop_front();
          check("sb_bus", mem_ctrl_bus, e);
          check("sb_bypass", 220'(ex_bypass), exp_bypass(e));
        end
      end
      if (left_valid && left_ready) exp_q.push_back(exp_bus(ex_ctrl_bus));
    end
  end

  // Present one entry and return #1 after the edge that accepted it.
  task automatic send(input logic [190:0] bus);
    bit ok;
    ok = 1'b0;
    ex_ctrl_bus = bus;
    left_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (left_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 220'(left_ready), 220'(1'b1));
    @(posedge clk); #1;
    left_valid = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [190:0] bus, input logic [31:0] exp_res);
    int lat, lr_low;
    lat = 0; lr_low = 0;
    right_ready = 1'b1;
    send(bus);
    for (int k = 1; k <= 60; k++) begin
      if (right_valid) begin lat = k; break; end
      if (!left_ready) lr_low++;
      @(posedge clk); #1;
    end
    check({tag, "_lat"}, 220'(lat), 220'(34));
    check({tag, "_lr_low"}, 220'(lr_low), 220'(33));
    check({tag, "_res"}, 220'(mem_ctrl_bus[31:0]), 220'(exp_res));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [190:0] a_bus, b_bus;
    logic [31:0]  x, y;
    int           stray;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rv", 220'(right_valid), 220'(1'b0));
    check("rst_lr", 220'(left_ready), 220'(1'b1));
    check("rst_bypass", 220'(ex_bypass), 220'(1'b0));
    check("rst_bus", mem_ctrl_bus, 220'(1'b0));
    reset = 1'b0;
    right_ready = 1'b1;
    @(posedge clk); #1;

    send(mk_bus(3'd0, 14'd1, 1'b1, 32'd5, 32'hFFFF_FFFF));
    check("add_rv", 220'(right_valid), 220'(1'b1));
    check("add_res", 220'(mem_ctrl_bus[31:0]), 220'(32'd4));
    @(posedge clk); #1;

    run_div("divs", mk_bus(3'b100, 14'd1, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    run_div("mods", mk_bus(3'b101, 14'd1, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    run_div("divu0", mk_bus(3'b110, 14'd1, 1'b1, 32'd7, 32'd0), 32'hFFFF_FFFF);
    run_div("modu0", mk_bus(3'b111, 14'd1, 1'b1, 32'd7, 32'd0), 32'd7);
    run_div("divovf", mk_bus(3'b100, 14'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    run_div("modovf", mk_bus(3'b101, 14'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    send(mk_bus(3'd2, 14'd1, 1'b1, 32'h8000_0000, 32'h8000_0000));
    check("mulh_res", 220'(mem_ctrl_bus[31:0]), 220'(32'h4000_0000));
    send(mk_bus(3'd1, 14'd1, 1'b1, 32'h8000_0000, 32'h8000_0000));
    check("mul_res", 220'(mem_ctrl_bus[31:0]), 220'(32'd0));
    @(posedge clk); #1;

    x = $urandom; y = $urandom;
    send(mk_bus(3'b100, 14'd1, 1'b0, x, y));
    check("iv0_rv", 220'(right_valid), 220'(1'b1));
    check("iv0_res", 220'(mem_ctrl_bus[31:0]), 220'(x + y));
    @(posedge clk); #1;

    right_ready = 1'b0;
    a_bus = mk_bus(3'd0, 14'd1 << 7, 1'b1, $urandom, $urandom);
    b_bus = mk_bus(3'd0, 14'd1 << 1, 1'b1, $urandom, $urandom);
    send(a_bus);
    ex_ctrl_bus = b_bus;
    left_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_lr", 220'(left_ready), 220'(1'b0));
      check("stall_rv", 220'(right_valid), 220'(1'b1));
      check("stall_bus", mem_ctrl_bus, exp_bus(a_bus));
      @(posedge clk); #1;
    end
    right_ready = 1'b1;
    @(posedge clk); #1;
    left_valid = 1'b0;
    check("stall_next", mem_ctrl_bus, exp_bus(b_bus));
    @(posedge clk); #1;

    send(mk_bus(3'b100, 14'd1, 1'b1, 32'd1000, 32'd7));
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("rstbusy_rv", 220'(right_valid), 220'(1'b0));
    check("rstbusy_lr", 220'(left_ready), 220'(1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (right_valid) stray++;
    end
    check("rstbusy_stray", 220'(stray), 220'(0));
    check("rstbusy_lr_after", 220'(left_ready), 220'(1'b1));

    for (int k = 0; k < 400; k++) begin
      ex_ctrl_bus = rand_bus();
      left_valid  = ($urandom_range(0, 3) != 0);
      right_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    left_valid  = 1'b0;
    right_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("sb_drain", 220'(exp_q.size()), 220'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
